// File: rtl/serial_block_subtractor.sv
// serial_block_subtractor
//   Computes diff = (a - b - bin) mod 2^WIDTH one 4-bit block per clock,
//   from the LSB block to the MSB block. Each side has a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b/bin are valid
//   in_ready   an operation can be accepted (IDLE only)
//   a, b       minuend / subtrahend, WIDTH bits
//   bin        borrow-in
//   out_valid  diff/bout/ovf are valid (DONE only)
//   out_ready  consumer takes the result
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       unsigned borrow-out (a < b + bin)
//   ovf        two's-complement overflow of a - b - bin
//
// state  | meaning
// -------+-----------------------------------------------------
// IDLE   | waiting for in_valid; operands captured on accept
// RUN    | one 4-bit block subtracted per cycle, index 0..N-1
// DONE   | result held with out_valid=1 until out_ready
module serial_block_subtractor #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [IW-1:0]    idx_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic [3:0] blk_a;
  logic [3:0] blk_b;
  logic [4:0] sum5;
  logic [3:0] low4;
  logic       borrow_out;
  logic       borrow_into_msb;

  // Subtraction as a + ~b + ~borrow; the carry-out is the inverted borrow.
  // low4 repeats the sum over bits [2:0] only, giving the borrow into bit 3
  // of the block, which for the last block is the borrow into bit WIDTH-1.
  always_comb begin
    blk_a           = a_q[{idx_q, 2'b00} +: 4];
    blk_b           = b_q[{idx_q, 2'b00} +: 4];
    sum5            = {1'b0, blk_a} + {1'b0, ~blk_b} + {4'b0000, ~borrow_q};
    low4            = {1'b0, blk_a[2:0]} + {1'b0, ~blk_b[2:0]} + {3'b000, ~borrow_q};
    borrow_out      = ~sum5[4];
    borrow_into_msb = ~low4[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            idx_q    <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          diff_q[{idx_q, 2'b00} +: 4] <= sum5[3:0];
          borrow_q                    <= borrow_out;
          if (idx_q == LAST_IDX) begin
            bout_q  <= borrow_out;
            ovf_q   <= borrow_into_msb ^ borrow_out;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule
